// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//   N-way round-robin arbiter with a bounded grant tenure. The grant is
//   registered, so a request sampled at one posedge is first visible as a
//   grant in the following cycle. No combinational path runs from request
//   to grant. An owner keeps the grant for at most HOLD_MAX consecutive
//   cycles while others are waiting. When nobody else requests, the owner is
//   re-granted without an idle bubble.
//
// Optional feature (macro ARB_LOCK_EN):
//   When defined, a `lock` input is added. With lock=1 and the owner still
//   requesting, the HOLD_MAX rotation is suppressed and hold_cnt saturates.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   synchronous reset, active low
//   request    in   N   request[i]=1: requester i wants the resource
//   lock       in   1   (ARB_LOCK_EN only) hold grant past HOLD_MAX
//   grant      out  N   one-hot-or-zero grant, registered
//   grant_vld  out  1   |grant, registered
//   grant_id   out  IW  index of granted requester, 0 when idle
//   hold_cnt   out  CW  cycles current owner has held grant, 0 when idle
// -----------------------------------------------------------------------------
module rr_burst_arbiter #(
   parameter  int N        = 4,
   parameter  int HOLD_MAX = 4,
   localparam int IW       = $clog2(N),
   localparam int CW       = $clog2(HOLD_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  request,
`ifdef ARB_LOCK_EN
   input  logic          lock,
`endif
   output logic [N-1:0]  grant,
   output logic          grant_vld,
   output logic [IW-1:0] grant_id,
   output logic [CW-1:0] hold_cnt
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0] LAST   = IW'(N - 1);
   localparam logic [CW-1:0] CNT_MX = CW'(HOLD_MAX);
   localparam logic [CW-1:0] CNT_1  = CW'(1);

   state_t        r_state;
   logic [N-1:0]  r_grant;
   logic          r_vld;
   logic [IW-1:0] r_id;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_ptr;

   state_t        w_state_n;
   logic [N-1:0]  w_grant_n;
   logic [IW-1:0] w_id_n;
   logic [CW-1:0] w_cnt_n;
   logic [IW-1:0] w_ptr_n;

   logic [N-1:0]  w_own_oh;
   logic [IW-1:0] w_own_nxt;
   logic          w_own_req;
   logic          w_lock;
   logic [IW-1:0] w_start;
   logic [N-1:0]  w_cand;
   logic          w_found;
   logic [IW-1:0] w_win;
   int            w_idx;

`ifdef ARB_LOCK_EN
   assign w_lock = lock;
`else
   assign w_lock = 1'b0;
`endif

   assign w_own_oh  = ONE_N << r_id;
   assign w_own_nxt = (r_id == LAST) ? '0 : r_id + IW'(1);
   assign w_own_req = (r_state == OWN) && request[r_id];

   // One scanner serves both cases: from the pointer over all requests when
   // idle, and from owner+1 with the owner masked out when rotating.
   always_comb begin
      if (r_state == IDLE) begin
         w_start = r_ptr;
         w_cand  = request;
      end else begin
         w_start = w_own_nxt;
         w_cand  = request & ~w_own_oh;
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(w_start) + k) % N;
         if (!w_found && w_cand[w_idx]) begin
            w_found = 1'b1;
            w_win   = IW'(w_idx);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_n = r_state;
      w_id_n    = r_id;
      w_cnt_n   = r_cnt;
      w_ptr_n   = r_ptr;
      if (r_state == IDLE) begin
         if (w_found) begin
            w_state_n = OWN;
            w_id_n    = w_win;
            w_cnt_n   = CNT_1;
            w_ptr_n   = (w_win == LAST) ? '0 : w_win + IW'(1);
         end
      end else begin
         if (w_own_req && (r_cnt < CNT_MX)) begin
            w_cnt_n = r_cnt + CNT_1;
         end else if (w_own_req && w_lock) begin
            w_cnt_n = CNT_MX;                 // locked tenure: saturate
         end else if (w_found) begin
            // Tenure expired (or owner dropped) and someone else waits.
            w_id_n  = w_win;
            w_cnt_n = CNT_1;
            w_ptr_n = (w_win == LAST) ? '0 : w_win + IW'(1);
         end else if (w_own_req) begin
            w_cnt_n = CNT_1;                  // sole requester: re-grant
         end else begin
            w_state_n = IDLE;
            w_id_n    = '0;
            w_cnt_n   = '0;
         end
      end
      w_grant_n = (w_state_n == OWN) ? (ONE_N << w_id_n) : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_vld   <= 1'b0;
         r_id    <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_n;
         r_grant <= w_grant_n;
         r_vld   <= (w_state_n == OWN);
         r_id    <= w_id_n;
         r_cnt   <= w_cnt_n;
         r_ptr   <= w_ptr_n;
      end
   end

   assign grant     = r_grant;
   assign grant_vld = r_vld;
   assign grant_id  = r_id;
   assign hold_cnt  = r_cnt;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;
   localparam int N   = 4;
   localparam int HM  = 4;
   localparam int IW  = 2;
   localparam int CW  = 3;
   localparam int LIM = (N - 1) * HM + 1;

   typedef struct packed {
      logic [N-1:0]  g;
      logic [CW-1:0] c;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [N-1:0]  request = '0;
`ifdef ARB_LOCK_EN
   logic          lock = 1'b0;
`endif
   logic [N-1:0]  grant;
   logic          grant_vld;
   logic [IW-1:0] grant_id;
   logic [CW-1:0] hold_cnt;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic chk_en = 1'b0;

   // reference model state
   int   m_vld, m_own, m_cnt, m_ptr;

   always #5 clk = ~clk;

   rr_burst_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .request(request),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .grant(grant),
      .grant_vld(grant_vld),
      .grant_id(grant_id),
      .hold_cnt(hold_cnt)
   );

   function automatic logic [IW-1:0] oh2id(input logic [N-1:0] g);
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
      return r;
   endfunction

   // ---------------- invariants ----------------
   a_onehot: assert property (@(posedge clk) disable iff (!chk_en)
      $onehot0(grant) && (grant_vld == (|grant)) && (grant_vld || grant_id == '0))
      else begin
         bad++;
         $display("FAIL sva_onehot got g=%b v=%b id=%0d", grant, grant_vld, grant_id);
      end

   a_req: assert property (@(posedge clk) disable iff (!chk_en)
      $past(reset_n) |-> ((grant & ~$past(request)) == '0))
      else begin
         bad++;
         $display("FAIL sva_req_implies got g=%b req_prev=%b", grant, $past(request));
      end

   a_sole: assert property (@(posedge clk) disable iff (!chk_en)
      ($past(reset_n) && $onehot($past(request))) |-> (grant == $past(request)))
      else begin
         bad++;
         $display("FAIL sva_sole got g=%b want %b", grant, $past(request));
      end

   // ---------------- helpers (no comparisons) ----------------
   task automatic do_reset();
      reset_n = 1'b0;
      request = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      q.delete();
      m_vld = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
   endtask

   task automatic model_next(input logic [N-1:0] req, output exp_t e);
      int w;
      bit own_req;
      w = -1;
      own_req = (m_vld != 0) && req[m_own];
      if (m_vld == 0) begin
         for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end else if (own_req && m_cnt < HM) begin
         m_cnt++;
      end else begin
         for (int k = 1; k < N; k++)
            if (w < 0 && req[(m_own + k) % N]) w = (m_own + k) % N;
         if (w < 0) begin
            if (own_req) m_cnt = 1;
            else begin m_vld = 0; m_own = 0; m_cnt = 0; end
         end
      end
      if (w >= 0) begin
         m_vld = 1; m_own = w; m_cnt = 1; m_ptr = (w + 1) % N;
      end
      e.g = (m_vld != 0) ? N'(1 << m_own) : '0;
      e.c = CW'(m_cnt);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         q.push_back('{g: 4'b0000, c: 3'd0});
         reset_n = 1'b0;
         request = 4'b1111;
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL reset[%0d] got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     i, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
      end
   endtask

   task automatic test_self_regrant();
      exp_t e;
      logic [CW-1:0] cs [6];
      cs = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2};
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         q.push_back('{g: 4'b0100, c: cs[i]});
         request = 4'b0100;
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL self_regrant[%0d] got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     i, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
      end
   endtask

   task automatic test_rotate();
      exp_t e;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         q.push_back('{g: N'(1 << (i / HM)), c: CW'((i % HM) + 1)});
         request = 4'b1111;
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL rotate[%0d] got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     i, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
      end
   endtask

   task automatic test_drop();
      exp_t e;
      logic [N-1:0]  rq [5];
      logic [N-1:0]  eg [5];
      logic [CW-1:0] ec [5];
      rq = '{4'b0101, 4'b0101, 4'b0100, 4'b0000, 4'b0000};
      eg = '{4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
      ec = '{3'd1,    3'd2,    3'd1,    3'd0,    3'd0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         q.push_back('{g: eg[i], c: ec[i]});
         request = rq[i];
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL drop[%0d] got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     i, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      logic [N-1:0]  rq [6];
      logic          rs [6];
      logic [N-1:0]  eg [6];
      logic [CW-1:0] ec [6];
      rq = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001};
      rs = '{1'b1,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1};
      eg = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
      ec = '{3'd1,    3'd2,    3'd3,    3'd0,    3'd1,    3'd2};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         q.push_back('{g: eg[i], c: ec[i]});
         request = rq[i];
         reset_n = rs[i];
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL mid_reset[%0d] got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     i, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
      end
      reset_n = 1'b1;
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      exp_t e;
      logic [N-1:0]  eg [9];
      logic [CW-1:0] ec [9];
      eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
             4'b0001, 4'b0001, 4'b0001, 4'b0010};
      ec = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         q.push_back('{g: eg[i], c: ec[i]});
         request = 4'b0011;
         lock    = (i < 8);
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL lock[%0d] got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     i, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
      end
      lock = 1'b0;
   endtask
`endif

   task automatic test_random();
      exp_t e, pe;
      int wt [N];
      int maxw;
      logic [N-1:0] rq;
      do_reset();
      rq = '0;
      maxw = 0;
      for (int i = 0; i < N; i++) wt[i] = 0;
      for (int n = 0; n < 600; n++) begin
         // mostly keep the previous pattern so long tenures and waits occur
         if ($urandom_range(0, 9) < 3) rq = N'($urandom_range(0, 15));
         model_next(rq, pe);
         q.push_back(pe);
         request = rq;
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if ({grant, grant_vld, grant_id, hold_cnt} !== {e.g, |e.g, oh2id(e.g), e.c}) begin
            bad++;
            $display("FAIL random[%0d] req=%b got g=%b v=%b id=%0d c=%0d want g=%b c=%0d",
                     n, rq, grant, grant_vld, grant_id, hold_cnt, e.g, e.c);
         end
         for (int i = 0; i < N; i++) begin
            if (rq[i] && !grant[i]) wt[i]++;
            else wt[i] = 0;
            if (wt[i] > maxw) maxw = wt[i];
         end
      end
      total++;
      if (maxw > LIM) begin
         bad++;
         $display("FAIL starvation got max_wait=%0d want <=%0d", maxw, LIM);
      end
      request = '0;
   endtask

   initial begin
      test_reset();
      chk_en = 1'b1;
      test_self_regrant();
      test_rotate();
      test_drop();
      test_mid_reset();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
